// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch and load/store, MEM first.
// Latency MEM_LAT+1 cycles per access; pipe_stall holds the pipeline until every need is done.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic [1:0]        mem_M,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mem_done;
    logic             if_done;
    logic             owner_mem;
    logic             lat_we;
    logic             mem_need;
    logic             if_need;

    assign mem_need   = |mem_M;
    assign if_need    = if_req;
    assign pipe_stall = (mem_need & ~mem_done) | (if_need & ~if_done);
    assign if_ready   = if_done;
    assign mem_ready  = mem_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_done  <= 1'b0;
            if_done   <= 1'b0;
            owner_mem <= 1'b0;
            lat_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            // Advance clears first so a completion on the same edge still sets its flag.
            if (!pipe_stall) begin
                mem_done <= 1'b0;
                if_done  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (mem_need && !mem_done) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        owner_mem <= 1'b1;
                        lat_we    <= mem_M[0];
                        ram_en    <= 1'b1;
                        ram_we    <= mem_M[0];
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                    end else if (if_need && !if_done) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        owner_mem <= 1'b0;
                        lat_we    <= 1'b0;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        if (owner_mem) begin
                            mem_done <= 1'b1;
                            if (!lat_we) mem_rdata <= ram_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between instruction fetch (IF) and the MEM stage's load/store.
- The MEM-stage request comes from the EX/MEM register's M field.
- Serialises the two requesters, with MEM given priority because it is the older instruction.
- Holds read data for each requester and raises a global pipeline stall until every pending access of the current pipeline cycle has completed.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- if_req  input  1  fetch request; held while pipe_stall=1.
- if_addr  input  ADDR_W  fetch address.
- if_ready  output  1  fetch data valid; held until advance.
- if_rdata  output  DATA_W  fetched word.
- mem_M  input  2  EX/MEM M field; bit1=MemRead, bit0=MemWrite.
- mem_addr  input  ADDR_W  load/store address (ALU result).
- mem_wdata  input  DATA_W  store data.
- mem_ready  output  1  load/store complete; held until advance.
- mem_rdata  output  DATA_W  load data.
- pipe_stall  output  1  freezes all pipeline registers and the PC.
- ram_en  output  1  memory enable.
- ram_we  output  1  memory write enable.
- ram_addr  output  ADDR_W  memory address.
- ram_wdata  output  DATA_W  memory write data.
- ram_rdata  input  DATA_W  memory read data; valid in the last BUSY cycle.

Behaviour:
- Derived signals:
  - mem_need = |mem_M
  - if_need = if_req
  - pipe_stall = (mem_need & ~mem_done) | (if_need & ~if_done), combinational
  - advance cycle = any cycle with pipe_stall=0
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE, cnt=0, mem_done=if_done=0, owner=0.
  - if_rdata=mem_rdata=0; latched addr/wdata/we=0.
  - This gives ram_en=ram_we=0 and ready=0.
  - Reset mid-BUSY abandons the access: ram_en is low in the next cycle and no done flag is set.
- States:
  - IDLE: no memory access.
  - BUSY: access in progress; cnt counts 0..MEM_LAT-1.
- IDLE → BUSY grant:
  - If mem_need & ~mem_done: owner=MEM; latch mem_addr, mem_wdata, we=mem_M[0].
  - Else if if_need & ~if_done: owner=IF; latch if_addr, we=0.
  - On either grant, cnt=0.
  - Otherwise stay in IDLE.
- BUSY outputs:
  - ram_en=1, ram_addr/ram_wdata/ram_we from the latched values, stable for all MEM_LAT cycles.
  - In IDLE, ram_en=0 and ram_we=0.
- BUSY completion:
  - When cnt==MEM_LAT-1: go to IDLE and set the owner's done flag.
  - For a read (owner IF, or MEM with we=0), capture ram_rdata into the owner's rdata register.
  - For a store, mem_rdata is unchanged.
  - Otherwise cnt increments.
- Ready outputs: if_ready=if_done and mem_ready=mem_done, both registered.
- Advance cycle: at its closing edge, clear both done flags. No grant is possible in that cycle because all needs are already done.
- Timing:
  - Single request sampled in IDLE at cycle T: BUSY T+1..T+MEM_LAT; ready=1 and pipe_stall=0 at T+MEM_LAT+1.
  - Simultaneous requests: MEM is served first (done at T+MEM_LAT+1); IF is granted in that same cycle and is done at T+2·MEM_LAT+2. Stall is held throughout.
- mem_M=2'b11 is illegal; it is treated as a write and no read capture occurs.
- A request withdrawn mid-BUSY still completes. Its done flag sets and clears at the next advance.
- If no request is present, pipe_stall=0 and the FSM stays in IDLE.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with if_req=1 → ram_en=0, pipe_stall=1, if_ready=0, rdata=0. After release, a grant occurs in the first cycle.
- IF-only read, MEM_LAT=2, if_addr=0x40, ram returns 0x1234ABCD:
  - Request at T → ram_en=1 with ram_addr=0x40 at T+1..T+2.
  - if_ready=1, if_rdata=0x1234ABCD, pipe_stall=0 at T+3.
  - if_ready=0 at T+4.
- MEM store, mem_M=01, addr=0x80, wdata=0xDEADBEEF, if_req=0:
  - ram_we=1 with addr/wdata stable for 2 cycles.
  - mem_ready at T+3; mem_rdata unchanged.
- Contention: if_req=1 and mem_M=10 at T:
  - MEM access runs T+1..T+2; IF access runs T+4..T+5.
  - pipe_stall=1 through T+5 and 0 at T+6.
  - mem_ready stays 1 from T+3 to T+6.
- Back-to-back: a new if_addr=0x44 presented right after the advance → new grant the following cycle, with no lost or duplicated access.
- Reset asserted at cycle 2 of an MEM_LAT=4 load → ram_en=0 and mem_ready=0 after the edge; a later request completes normally.
